// File: rtl/parking_pkg.sv
// Shared definitions for the parking entry-gate controller: state codes and
// width helpers used to size the occupancy counter and the shared state timer.
package parking_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_PASS  = 3'd1,
        ST_WRONG_PASS = 3'd2,
        ST_RIGHT_PASS = 3'd3,
        ST_STOP       = 3'd4,
        ST_LOCKOUT    = 3'd5
    } gate_state_t;

    localparam int STATE_W = 3;

    function automatic int occ_width(input int capacity);
        return $clog2(capacity + 1);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // One timer serves every waiting state, so it must reach the longest timeout.
    function automatic int timer_width(input int a, input int b, input int c);
        return $clog2(max3(a, b, c) + 1);
    endfunction

endpackage

// File: rtl/parking_occ_counter.sv
// Occupancy counter for the lot: saturating increment on admission, decrement on
// departure with underflow protection, and a registered full flag.
module parking_occ_counter
    import parking_pkg::*;
#(
    parameter int  CAPACITY = 16,
    localparam int OCC_W    = occ_width(CAPACITY)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             dec,
    output logic [OCC_W-1:0] occupancy,
    output logic             full
);

    logic [OCC_W-1:0] occ_q;
    logic             full_q;

    // A simultaneous admit and departure cancel out; full follows occupancy one cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ_q  <= '0;
            full_q <= 1'b0;
        end else begin
            case ({inc, dec})
                2'b10: if (occ_q < OCC_W'(CAPACITY)) occ_q <= occ_q + OCC_W'(1);
                2'b01: if (occ_q != '0)              occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
            full_q <= (occ_q == OCC_W'(CAPACITY));
        end
    end

    assign occupancy = occ_q;
    assign full      = full_q;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Entry-gate controller: password check with retry limit and alarm lockout,
// timeouts on waiting states, tailgate stop, and occupancy-based entry refusal.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int              CAPACITY     = 16,
    parameter int              PW_W         = 4,
    parameter logic [PW_W-1:0] PASSWORD     = 'h6,
    parameter int              MAX_TRIES    = 3,
    parameter int              PW_TIMEOUT   = 128,
    parameter int              GATE_TIMEOUT = 256,
    parameter int              LOCK_CYCLES  = 64,
    localparam int             OCC_W        = occ_width(CAPACITY)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sensor_entrance,
    input  logic             sensor_exit,
    input  logic             pw_valid,
    input  logic [PW_W-1:0]  pw_data,
    input  logic             car_leave,
    output logic [2:0]       state_out,
    output logic             gate_open,
    output logic             alarm,
    output logic             full,
    output logic [OCC_W-1:0] occupancy
);

    localparam int TMR_W = timer_width(PW_TIMEOUT, GATE_TIMEOUT, LOCK_CYCLES);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    gate_state_t      state_q, state_d;
    logic [TRY_W-1:0] tries_q, tries_d, tries_inc;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             admit;
    logic             pw_match;
    logic             in_pw_state;
    logic             full_flag;

    assign pw_match    = pw_valid && (pw_data == PASSWORD);
    assign in_pw_state = (state_q == ST_WAIT_PASS) || (state_q == ST_WRONG_PASS);
    // The first wrong entry always counts as one, whatever was left over.
    assign tries_inc   = (state_q == ST_WAIT_PASS) ? TRY_W'(1) : tries_q + TRY_W'(1);

    always_comb begin
        state_d = state_q;
        tries_d = tries_q;
        admit   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sensor_entrance && !sensor_exit && !full_flag)
                    state_d = ST_WAIT_PASS;
            end
            ST_WAIT_PASS, ST_WRONG_PASS: begin
                if (pw_match) begin
                    state_d = ST_RIGHT_PASS;
                end else if (pw_valid) begin
                    tries_d = tries_inc;
                    state_d = (tries_inc >= TRY_W'(MAX_TRIES)) ? ST_LOCKOUT : ST_WRONG_PASS;
                end else if (timer_q == TMR_W'(PW_TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RIGHT_PASS: begin
                if (sensor_entrance && sensor_exit) begin
                    state_d = ST_STOP;
                end else if (sensor_exit) begin
                    // A lot that filled while this car waited refuses the count.
                    state_d = ST_IDLE;
                    admit   = !full_flag;
                end else if (timer_q == TMR_W'(GATE_TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STOP: begin
                if (sensor_entrance && !sensor_exit)
                    state_d = ST_WAIT_PASS;
            end
            ST_LOCKOUT: begin
                if (timer_q == TMR_W'(LOCK_CYCLES - 1))
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_d != state_q) && ((state_d == ST_IDLE) || (state_d == ST_RIGHT_PASS)))
            tries_d = '0;
    end

    always_comb begin
        timer_d = timer_q;
        if ((state_d != state_q) || (pw_valid && in_pw_state))
            timer_d = '0;
        else if (timer_q != '1)
            timer_d = timer_q + TMR_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            tries_q <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            tries_q <= tries_d;
            timer_q <= timer_d;
        end
    end

    parking_occ_counter #(
        .CAPACITY (CAPACITY)
    ) u_occ (
        .clk       (clk),
        .reset_n   (reset_n),
        .inc       (admit),
        .dec       (car_leave),
        .occupancy (occupancy),
        .full      (full_flag)
    );

    assign state_out = state_q;
    assign gate_open = (state_q == ST_RIGHT_PASS);
    assign alarm     = (state_q == ST_LOCKOUT);
    assign full      = full_flag;

endmodule
